// File: rtl/machine_ctrl_pkg.sv
// Shared definitions for the machine control block: sequencer state encoding,
// reset release-order indices and a timer sizing helper.
package machine_ctrl_pkg;

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    REL_RF  = 3'd1,
    REL_INT = 3'd2,
    REL_PC  = 3'd3,
    REL_SEQ = 3'd4,
    RUN     = 3'd5,
    HALT    = 3'd6
  } rst_seq_state_t;

  // Bit positions of the per-unit resets inside the sequencer's reset vector.
  localparam int REL_IDX_RF  = 0;
  localparam int REL_IDX_INT = 1;
  localparam int REL_IDX_PC  = 2;
  localparam int REL_IDX_SEQ = 3;

  // Width needed to hold (max(a, b) - 1), never less than one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down counter; done is high whenever the count has reached zero.
// The parent loads it on every phase entry, so it needs no reset of its own.
module rst_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Reset and run-control sequencer: staged release of the four unit resets,
// run-cycle counter, warm reset with ack. Watchdog halt built under RST_SEQ_WATCHDOG_EN.
module reset_sequencer
  import machine_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int STAGGER     = 0,
  parameter int RUN_LIMIT   = 200,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset_req,
  output logic             soft_reset_ack,
  output logic             reg_file_reset,
  output logic             interrupt_reset,
  output logic             pc_reset,
  output logic             seq_reset,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output rst_seq_state_t   state_dbg
);

  localparam int               TMR_W     = tmr_width(HOLD_CYCLES, STAGGER);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAG_LOAD = (STAGGER > 0) ? TMR_W'(STAGGER - 1) : '0;

  rst_seq_state_t   state_q, state_d;
  logic [3:0]       rst_q, rst_d;
  logic             running_q, running_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef RST_SEQ_WATCHDOG_EN
  logic             halted_q, halted_d;
`endif

  logic             warm;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  rst_seq_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // A warm request only counts once the machine has been fully released.
  assign warm = soft_reset_req && ((state_q == RUN) || (state_q == HALT));

  always_comb begin
    state_d   = state_q;
    rst_d     = rst_q;
    running_d = running_q;
    ack_d     = 1'b0;
    count_d   = count_q;
`ifdef RST_SEQ_WATCHDOG_EN
    halted_d  = halted_q;
`endif
    tmr_load  = 1'b0;
    tmr_val   = HOLD_LOAD;

    // REL_x means x has just been released and the stagger to the next one runs.
    unique case (state_q)
      ASSERT: begin
        if (tmr_done) begin
          if (STAGGER == 0) begin
            rst_d     = '0;
            running_d = 1'b1;
            state_d   = RUN;
          end else begin
            rst_d[REL_IDX_RF] = 1'b0;
            state_d  = REL_RF;
            tmr_load = 1'b1;
            tmr_val  = STAG_LOAD;
          end
        end
      end
      REL_RF: begin
        if (tmr_done) begin
          rst_d[REL_IDX_INT] = 1'b0;
          state_d  = REL_INT;
          tmr_load = 1'b1;
          tmr_val  = STAG_LOAD;
        end
      end
      REL_INT: begin
        if (tmr_done) begin
          rst_d[REL_IDX_PC] = 1'b0;
          state_d  = REL_PC;
          tmr_load = 1'b1;
          tmr_val  = STAG_LOAD;
        end
      end
      REL_PC: begin
        if (tmr_done) begin
          rst_d[REL_IDX_SEQ] = 1'b0;
          running_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
`ifdef RST_SEQ_WATCHDOG_EN
        // Only the sequencer is held so the rest of the machine stays inspectable.
        if (32'(count_d) == 32'(RUN_LIMIT)) begin
          halted_d           = 1'b1;
          running_d          = 1'b0;
          rst_d[REL_IDX_SEQ] = 1'b1;
          state_d            = HALT;
        end
`endif
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = ASSERT;
      end
    endcase

    if (warm) begin
      state_d   = ASSERT;
      rst_d     = '1;
      running_d = 1'b0;
      count_d   = '0;
      ack_d     = 1'b1;
`ifdef RST_SEQ_WATCHDOG_EN
      halted_d  = 1'b0;
`endif
      tmr_load  = 1'b1;
      tmr_val   = HOLD_LOAD;
    end

    if (reset) begin
      tmr_load = 1'b1;
      tmr_val  = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ASSERT;
      rst_q     <= '1;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
      count_q   <= '0;
`ifdef RST_SEQ_WATCHDOG_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rst_q     <= rst_d;
      running_q <= running_d;
      ack_q     <= ack_d;
      count_q   <= count_d;
`ifdef RST_SEQ_WATCHDOG_EN
      halted_q  <= halted_d;
`endif
    end
  end

  assign reg_file_reset  = rst_q[REL_IDX_RF];
  assign interrupt_reset = rst_q[REL_IDX_INT];
  assign pc_reset        = rst_q[REL_IDX_PC];
  assign seq_reset       = rst_q[REL_IDX_SEQ];
  assign running         = running_q;
  assign soft_reset_ack  = ack_q;
  assign cycle_count     = count_q;
  assign state_dbg       = state_q;
`ifdef RST_SEQ_WATCHDOG_EN
  assign halted          = halted_q;
`else
  assign halted          = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three differently parameterised instances share
// reset/request inputs and are compared against a timeline-based model.
module tb_reset_sequencer;
  import machine_ctrl_pkg::*;

`ifdef RST_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // Per-instance parameters: a = defaults, b = hold 3 / stagger 2, c = watchdog at 10.
  localparam int HP[3]   = '{1, 3, 2};
  localparam int SP[3]   = '{0, 2, 1};
  localparam int LP[3]   = '{200, 200, 10};
  localparam int MAXC[3] = '{65535, 15, 31};

  logic clk;
  logic rst;
  logic req;
  logic [2:0] ack, rf, intr, pc, sq, run, hlt;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [4:0]  cnt_c;
  rst_seq_state_t st_a, st_b, st_c;

  int checks;
  int errors;

  bit m_inseq[3];
  int m_t[3];
  int m_cnt[3];
  bit m_halt[3];
  bit m_ack[3];

  reset_sequencer #(.HOLD_CYCLES(1), .STAGGER(0), .RUN_LIMIT(200), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst), .soft_reset_req(req), .soft_reset_ack(ack[0]),
    .reg_file_reset(rf[0]), .interrupt_reset(intr[0]), .pc_reset(pc[0]), .seq_reset(sq[0]),
    .running(run[0]), .halted(hlt[0]), .cycle_count(cnt_a), .state_dbg(st_a)
  );
  reset_sequencer #(.HOLD_CYCLES(3), .STAGGER(2), .RUN_LIMIT(200), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst), .soft_reset_req(req), .soft_reset_ack(ack[1]),
    .reg_file_reset(rf[1]), .interrupt_reset(intr[1]), .pc_reset(pc[1]), .seq_reset(sq[1]),
    .running(run[1]), .halted(hlt[1]), .cycle_count(cnt_b), .state_dbg(st_b)
  );
  reset_sequencer #(.HOLD_CYCLES(2), .STAGGER(1), .RUN_LIMIT(10), .CNT_W(5)) dut_c (
    .clk(clk), .reset(rst), .soft_reset_req(req), .soft_reset_ack(ack[2]),
    .reg_file_reset(rf[2]), .interrupt_reset(intr[2]), .pc_reset(pc[2]), .seq_reset(sq[2]),
    .running(run[2]), .halted(hlt[2]), .cycle_count(cnt_c), .state_dbg(st_c)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: while sequencing, outputs follow from edges elapsed since entry.
  task automatic model_step(input bit r, input bit s);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_inseq[i] = 1'b1; m_t[i] = 0; m_cnt[i] = 0; m_halt[i] = 1'b0; m_ack[i] = 1'b0;
      end else begin
        m_ack[i] = 1'b0;
        if (m_inseq[i]) begin
          m_t[i]++;
          if (m_t[i] >= HP[i] + 3 * SP[i]) m_inseq[i] = 1'b0;
        end else if (s) begin
          m_inseq[i] = 1'b1; m_t[i] = 0; m_cnt[i] = 0; m_halt[i] = 1'b0; m_ack[i] = 1'b1;
        end else if (!m_halt[i]) begin
          if (m_cnt[i] < MAXC[i]) m_cnt[i]++;
          if (WD && m_cnt[i] == LP[i]) m_halt[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [22:0] exp_vec(input int i);
    logic [6:0] f;
    if (m_inseq[i])
      f = {m_t[i] < HP[i], m_t[i] < HP[i] + SP[i], m_t[i] < HP[i] + 2 * SP[i],
           1'b1, 1'b0, 1'b0, m_ack[i]};
    else
      f = {3'b000, m_halt[i], !m_halt[i], m_halt[i], m_ack[i]};
    return {16'(m_cnt[i]), f};
  endfunction

  // {count, rf, int, pc, seq, running, halted, ack}
  function automatic logic [22:0] act_vec(input int i);
    logic [15:0] c;
    case (i)
      0:       c = cnt_a;
      1:       c = {12'd0, cnt_b};
      default: c = {11'd0, cnt_c};
    endcase
    return {c, rf[i], intr[i], pc[i], sq[i], run[i], hlt[i], ack[i]};
  endfunction

  // driver: inputs change on the falling edge, outputs are read there too
  task automatic tick(input bit r, input bit s);
    rst = r;
    req = s;
    @(posedge clk);
    model_step(r, s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== {16'd0, 7'b1111_000}) begin
        errors++;
        $display("FAIL reset_values dut%0d: got %h want %h", i, act_vec(i), {16'd0, 7'b1111_000});
      end
    end
  endtask

  task automatic test_cold_defaults();
    tick(1'b0, 1'b0);
    checks++;
    if (act_vec(0) !== {16'd0, 7'b0000_100}) begin
      errors++;
      $display("FAIL cold_release_defaults: got %h want %h", act_vec(0), {16'd0, 7'b0000_100});
    end
    repeat (5) tick(1'b0, 1'b0);
    checks++;
    if (cnt_a !== 16'd5) begin
      errors++;
      $display("FAIL count_after_5: got %0d want 5", cnt_a);
    end
  endtask

  task automatic test_stagger();
    int rel_e[5];
    int want[5];
    want = '{3, 5, 7, 9, 9};
    rel_e = '{-1, -1, -1, -1, -1};
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick(1'b0, 1'b0);
      if (rel_e[0] < 0 && rf[1] === 1'b0)   rel_e[0] = e;
      if (rel_e[1] < 0 && intr[1] === 1'b0) rel_e[1] = e;
      if (rel_e[2] < 0 && pc[1] === 1'b0)   rel_e[2] = e;
      if (rel_e[3] < 0 && sq[1] === 1'b0)   rel_e[3] = e;
      if (rel_e[4] < 0 && run[1] === 1'b1)  rel_e[4] = e;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (rel_e[j] != want[j]) begin
        errors++;
        $display("FAIL stagger_edge[%0d]: got %0d want %0d", j, rel_e[j], want[j]);
      end
    end
  endtask

  task automatic test_soft_run();
    tick(1'b1, 1'b0);
    repeat (21) tick(1'b0, 1'b0);
    checks++;
    if (cnt_a !== 16'd20) begin
      errors++;
      $display("FAIL soft_pre_count: got %0d want 20", cnt_a);
    end
    tick(1'b0, 1'b1);
    checks++;
    if (act_vec(0) !== {16'd0, 7'b1111_001}) begin
      errors++;
      $display("FAIL soft_accept: got %h want %h", act_vec(0), {16'd0, 7'b1111_001});
    end
    tick(1'b0, 1'b1);
    checks++;
    if ({ack[0], run[0]} !== 2'b01) begin
      errors++;
      $display("FAIL soft_ack_one_cycle: got ack=%b run=%b want ack=0 run=1", ack[0], run[0]);
    end
    tick(1'b0, 1'b1);
    checks++;
    if (ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL soft_held_second: got ack=%b want 1", ack[0]);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL soft_ack_drop: got ack=%b want 0", ack[0]);
    end
  endtask

  task automatic test_soft_rel_int();
    int rel_e[3];
    int want[3];
    bit b_ack;
    want = '{7, 9, 9};
    rel_e = '{-1, -1, -1};
    b_ack = 1'b0;
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick(1'b0, e == 6);
      if (ack[1] === 1'b1) b_ack = 1'b1;
      if (rel_e[0] < 0 && pc[1] === 1'b0)  rel_e[0] = e;
      if (rel_e[1] < 0 && sq[1] === 1'b0)  rel_e[1] = e;
      if (rel_e[2] < 0 && run[1] === 1'b1) rel_e[2] = e;
    end
    checks++;
    if (b_ack !== 1'b0) begin
      errors++;
      $display("FAIL rel_int_no_ack: got ack seen=%b want 0", b_ack);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rel_e[j] != want[j]) begin
        errors++;
        $display("FAIL rel_int_edge[%0d]: got %0d want %0d", j, rel_e[j], want[j]);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [22:0] want_v;
    tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0);
    want_v = WD ? {16'd10, 7'b0001_010} : {16'd10, 7'b0000_100};
    checks++;
    if (act_vec(2) !== want_v) begin
      errors++;
      $display("FAIL watchdog_at_limit: got %h want %h", act_vec(2), want_v);
    end
    repeat (5) tick(1'b0, 1'b0);
    checks++;
    if (cnt_c !== (WD ? 5'd10 : 5'd15)) begin
      errors++;
      $display("FAIL watchdog_freeze: got %0d want %0d", cnt_c, WD ? 10 : 15);
    end
    tick(1'b0, 1'b1);
    checks++;
    if ({hlt[2], ack[2], sq[2], cnt_c} !== {3'b011, 5'd0}) begin
      errors++;
      $display("FAIL watchdog_soft_clear: got halted=%b ack=%b seq=%b cnt=%0d want 0 1 1 0",
               hlt[2], ack[2], sq[2], cnt_c);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    tick(1'b1, 1'b0);
    repeat (45) tick(1'b0, 1'b0);
    checks++;
    if (cnt_b !== 4'hf) begin
      errors++;
      $display("FAIL saturate_b: got %0d want 15", cnt_b);
    end
    checks++;
    if (cnt_c !== (WD ? 5'd10 : 5'd31)) begin
      errors++;
      $display("FAIL saturate_c: got %0d want %0d", cnt_c, WD ? 10 : 31);
    end
  endtask

  task automatic test_reset_with_soft();
    tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== {16'd0, 7'b1111_000}) begin
        errors++;
        $display("FAIL reset_over_soft dut%0d: got %h want %h", i, act_vec(i), {16'd0, 7'b1111_000});
      end
    end
  endtask

  task automatic test_random();
    bit r, s;
    tick(1'b1, 1'b0);
    s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 79) == 0);
      if (s) s = ($urandom_range(0, 3) != 0);
      else   s = ($urandom_range(0, 24) == 0);
      tick(r, s);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random_cycle%0d dut%0d: got %h want %h", n, i, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 1'b0;
    test_reset();
    test_cold_defaults();
    test_stagger();
    test_soft_run();
    test_soft_rel_int();
    test_watchdog();
    test_saturation();
    test_reset_with_soft();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
